// File: rtl/snes_pkg.sv
// Shared definitions for the SNES pad reader: FSM states, button bit positions
// within the serial frame, and the key codes handed to keyboard_decoder.
package snes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        HIGH,
        LOW,
        DONE,
        STROBE
    } state_e;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned NUM_BTNS   = 12;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    localparam logic [7:0] KEY_NONE   = 8'h00;
    localparam logic [7:0] KEY_B      = 8'h01;
    localparam logic [7:0] KEY_Y      = 8'h02;
    localparam logic [7:0] KEY_SELECT = 8'h03;
    localparam logic [7:0] KEY_START  = 8'h04;
    localparam logic [7:0] KEY_UP     = 8'h05;
    localparam logic [7:0] KEY_DOWN   = 8'h06;
    localparam logic [7:0] KEY_LEFT   = 8'h07;
    localparam logic [7:0] KEY_RIGHT  = 8'h08;
    localparam logic [7:0] KEY_A      = 8'h09;
    localparam logic [7:0] KEY_X      = 8'h0A;
    localparam logic [7:0] KEY_L      = 8'h0B;
    localparam logic [7:0] KEY_R      = 8'h0C;

endpackage

// File: rtl/snes_pad_reader_if.sv
// Key bus from the pad reader to keyboard_decoder.
//   key_dec   : encoded key code
//   key_latch : one-cycle strobe, key_dec stable before and during it
//   buttons   : last frame's pressed mask, active-high
//   busy      : a pad frame is in progress
interface snes_pad_reader_if;
    import snes_pkg::*;

    logic [7:0]          key_dec;
    logic                key_latch;
    logic [NUM_BTNS-1:0] buttons;
    logic                busy;

    modport master (output key_dec, output key_latch, output buttons, output busy);
    modport slave  (input key_dec, input key_latch, input buttons, input busy);

endinterface

// File: rtl/snes_btn_encoder.sv
// Combinational priority encoder: lowest set bit i of the pressed mask gives
// code i+1; an empty mask gives KEY_NONE.
//   mask : pressed buttons, active-high
//   code : 8-bit key code
module snes_btn_encoder
    import snes_pkg::*;
(
    input  logic [NUM_BTNS-1:0] mask,
    output logic [7:0]          code
);

    always_comb begin
        code = KEY_NONE;
        // Scan downwards so the lowest set index is the last write.
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                code = KEY_B + 8'(i);
            end
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// Polls an SNES controller: pulses pad_latch, clocks 16 bits out with pad_clk,
// then publishes the pressed mask and its priority-encoded key code with a
// one-cycle key_latch strobe.
//   clk, rst_n : system clock, asynchronous active-low reset
//   enable     : polling enable, only looked at while idle
//   pad_data   : serial controller data, active-low, asynchronous
//   pad_latch  : controller latch, active-high
//   pad_clk    : controller clock, idles high
//   key        : key bus (key_dec, key_latch, buttons, busy)
module snes_pad_reader
    import snes_pkg::*;
#(
    parameter int unsigned HALF_CYC = 300,
    parameter int unsigned POLL_CYC = 833333
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pad_data,
    output logic                 pad_latch,
    output logic                 pad_clk,
    snes_pad_reader_if.master    key
);

    localparam int unsigned TMAX = (POLL_CYC > 2 * HALF_CYC) ? POLL_CYC : 2 * HALF_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] POLL_LOAD  = TW'(POLL_CYC - 1);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(2 * HALF_CYC - 1);
    localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYC - 1);

    logic [1:0]          sync_q;
    logic                data_s;
    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [3:0]          idx_q, idx_d;
    logic [NUM_BTNS-1:0] shift_q, shift_d;
    logic [NUM_BTNS-1:0] pressed;
    logic [7:0]          code;

    logic                pad_latch_q, pad_clk_q, key_latch_q, busy_q;
    logic [7:0]          key_dec_q;
    logic [NUM_BTNS-1:0] buttons_q;

    assign data_s  = sync_q[1];
    assign pressed = ~shift_q;

    snes_btn_encoder u_encoder (
        .mask (pressed),
        .code (code)
    );

    // Idle-high reset value keeps a reset from looking like a pressed button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pad_data};
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!enable) begin
                    timer_d = POLL_LOAD;
                end else if (timer_q == '0) begin
                    state_d = LATCH;
                    timer_d = LATCH_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LATCH: begin
                if (timer_q == '0) begin
                    state_d = HIGH;
                    timer_d = HALF_LOAD;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            HIGH: begin
                if (timer_q == '0) begin
                    // Only the last-cycle sample counts; bits 12-15 are clocked
                    // through but not kept.
                    if (idx_q < 4'(NUM_BTNS)) begin
                        shift_d[idx_q] = data_s;
                    end
                    if (idx_q == 4'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        timer_d = HALF_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOW: begin
                if (timer_q == '0) begin
                    state_d = HIGH;
                    timer_d = HALF_LOAD;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
                state_d = STROBE;
            end
            STROBE: begin
                state_d = IDLE;
                timer_d = POLL_LOAD;
            end
            default: begin
                state_d = IDLE;
                timer_d = POLL_LOAD;
            end
        endcase
    end

    // Timer resets to the full poll load: zero poll cycles elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= POLL_LOAD;
            idx_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    // Results load on DONE entry (bits 0-11 are final by then), one cycle ahead
    // of the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            key_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            key_dec_q   <= KEY_NONE;
            buttons_q   <= '0;
        end else begin
            pad_latch_q <= (state_d == LATCH);
            pad_clk_q   <= (state_d != LOW);
            key_latch_q <= (state_d == STROBE);
            busy_q      <= (state_d != IDLE);
            if (state_d == DONE) begin
                key_dec_q <= code;
                buttons_q <= pressed;
            end
        end
    end

    assign pad_latch     = pad_latch_q;
    assign pad_clk       = pad_clk_q;
    assign key.key_dec   = key_dec_q;
    assign key.key_latch = key_latch_q;
    assign key.buttons   = buttons_q;
    assign key.busy      = busy_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader with a behavioural SNES pad model.
module tb_snes_pad_reader;
    import snes_pkg::*;

    localparam int unsigned HALF  = 4;
    localparam int unsigned POLL  = 16;
    localparam int          BOUND = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic pad_data;
    logic pad_latch, pad_clk;

    snes_pad_reader_if key ();

    snes_pad_reader #(
        .HALF_CYC (HALF),
        .POLL_CYC (POLL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .key       (key)
    );

    always #5 clk = ~clk;

    // Pad model: latch selects bit 0, each pad_clk rising edge advances.
    logic [11:0] press = '0;
    logic        stuck_lo = 1'b0, stuck_hi = 1'b0, glitch = 1'b0;
    logic [3:0]  pad_idx = '0;
    logic [15:0] frame_bits;

    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pad_idx <= '0;
        else           pad_idx <= pad_idx + 4'd1;
    end

    assign frame_bits = {4'hF, ~press};
    assign pad_data   = glitch ? 1'b0 : stuck_lo ? 1'b0 : stuck_hi ? 1'b1 : frame_bits[pad_idx];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame measurement results.
    int          m_wait, m_latch, m_lows, m_lowcyc, m_busy, m_spur;
    bit          m_got;
    logic [7:0]  m_key, m_key_pre, m_key_start;
    logic [11:0] m_btn;

    // Wait for the next latch, then sample every cycle up to the strobe.
    task automatic run_frame();
        int   guard;
        logic prev_clk;
        m_wait = 0; m_latch = 0; m_lows = 0; m_lowcyc = 0; m_busy = 0; m_spur = 0;
        m_got = 0; m_key = '0; m_key_pre = '0; m_btn = '0;
        guard = 0;
        prev_clk = 1'b1;
        while (!pad_latch && guard < BOUND) begin
            step();
            m_wait++;
            guard++;
            if (key.key_latch && !pad_latch) m_spur++;
        end
        m_key_start = key.key_dec;
        while (guard < BOUND) begin
            if (pad_latch) m_latch++;
            if (!pad_clk) begin
                m_lowcyc++;
                if (prev_clk) m_lows++;
            end
            prev_clk = pad_clk;
            if (key.busy) m_busy++;
            if (key.key_latch) begin
                m_key = key.key_dec;
                m_btn = key.buttons;
                m_got = 1;
                break;
            end
            m_key_pre = key.key_dec;
            step();
            guard++;
        end
    endtask

    typedef struct {
        logic [11:0] press;
        logic [1:0]  mode;   // 0 model, 1 stuck low, 2 stuck high
        logic [7:0]  key;
        logic [11:0] btn;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          g, falls, rises, viol;
        logic        prev;
        logic [7:0]  prev_key;

        vecs[0]  = '{12'(1 << BTN_UP), 2'd0, KEY_UP, 12'h010};
        vecs[1]  = '{12'((1 << BTN_B) | (1 << BTN_RIGHT) | (1 << BTN_X)), 2'd0, KEY_B, 12'h281};
        vecs[2]  = '{12'((1 << BTN_RIGHT) | (1 << BTN_X)), 2'd0, KEY_RIGHT, 12'h280};
        vecs[3]  = '{12'h381, 2'd0, 8'h01, 12'h381};
        vecs[4]  = '{12'h380, 2'd0, 8'h08, 12'h380};
        vecs[5]  = '{12'((1 << BTN_L) | (1 << BTN_R)), 2'd0, 8'h0B, 12'hC00};
        vecs[6]  = '{12'(1 << BTN_R), 2'd0, 8'h0C, 12'h800};
        vecs[7]  = '{12'(1 << BTN_SELECT), 2'd0, 8'h03, 12'h004};
        vecs[8]  = '{12'h000, 2'd1, 8'h01, 12'hFFF};
        vecs[9]  = '{12'h000, 2'd2, 8'h00, 12'h000};
        vecs[10] = '{12'(1 << BTN_X), 2'd0, 8'h0A, 12'h200};

        // Reset values.
        #2 rst_n = 1'b0;
        #3;
        check("reset pad_latch", 32'(pad_latch), 32'h0);
        check("reset pad_clk", 32'(pad_clk), 32'h1);
        check("reset key_dec", 32'(key.key_dec), 32'h00);
        check("reset key_latch", 32'(key.key_latch), 32'h0);
        check("reset buttons", 32'(key.buttons), 32'h000);
        check("reset busy", 32'(key.busy), 32'h0);

        // First frame, nothing pressed.
        enable = 1'b1;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame();
        check("first latch delay", 32'(m_wait), 32'd16);
        check("latch high cycles", 32'(m_latch), 32'd8);
        check("pad_clk low pulses", 32'(m_lows), 32'd15);
        check("pad_clk low cycles", 32'(m_lowcyc), 32'd60);
        check("frame strobe seen", 32'(m_got), 32'h1);
        check("frame length", 32'(m_busy), 32'd134);
        check("idle key_dec", 32'(m_key), 32'h00);
        check("idle buttons", 32'(m_btn), 32'h000);
        step();
        check("strobe one cycle", 32'(key.key_latch), 32'h0);
        prev_key = 8'h00;

        foreach (vecs[i]) begin
            press    = vecs[i].press;
            stuck_lo = (vecs[i].mode == 2'd1);
            stuck_hi = (vecs[i].mode == 2'd2);
            run_frame();
            check($sformatf("v%0d strobe seen", i), 32'(m_got), 32'h1);
            check($sformatf("v%0d key held", i), 32'(m_key_start), 32'(prev_key));
            check($sformatf("v%0d key before strobe", i), 32'(m_key_pre), 32'(vecs[i].key));
            check($sformatf("v%0d key_dec", i), 32'(m_key), 32'(vecs[i].key));
            check($sformatf("v%0d buttons", i), 32'(m_btn), 32'(vecs[i].btn));
            check($sformatf("v%0d frame length", i), 32'(m_busy), 32'd134);
            step();
            check($sformatf("v%0d strobe width", i), 32'(key.key_latch), 32'h0);
            prev_key = vecs[i].key;
        end
        stuck_lo = 1'b0;
        stuck_hi = 1'b0;

        // Drop enable during LOW of bit 7; frame still completes.
        press = 12'(1 << BTN_SELECT);
        g = 0;
        while (!pad_latch && g < BOUND) begin step(); g++; end
        prev = pad_clk;
        falls = 0;
        while (!key.key_latch && g < BOUND) begin
            step();
            g++;
            if (prev && !pad_clk) falls++;
            if (falls == 8 && enable) enable = 1'b0;
            prev = pad_clk;
        end
        check("disabled frame strobe", 32'(key.key_latch), 32'h1);
        check("disabled frame key_dec", 32'(key.key_dec), 32'h03);
        viol = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (pad_latch || key.busy) viol++;
        end
        check("idle while disabled", 32'(viol), 32'd0);
        enable = 1'b1;
        g = 0;
        while (!pad_latch && g < BOUND) begin step(); g++; end
        check("latch after re-enable", 32'(g), 32'd16);

        // Reset during HIGH of bit 10.
        prev = pad_clk;
        rises = 0;
        g = 0;
        while (rises < 10 && g < BOUND) begin
            step();
            g++;
            if (!prev && pad_clk) rises++;
            prev = pad_clk;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort pad_clk", 32'(pad_clk), 32'h1);
        check("abort pad_latch", 32'(pad_latch), 32'h0);
        check("abort key_dec", 32'(key.key_dec), 32'h00);
        check("abort key_latch", 32'(key.key_latch), 32'h0);
        check("abort busy", 32'(key.busy), 32'h0);
        step();
        step();
        check("abort no strobe", 32'(key.key_latch), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame();
        check("latch after abort", 32'(m_wait), 32'd16);
        check("no strobe after abort", 32'(m_spur), 32'd0);
        check("frame after abort", 32'(m_key), 32'h03);

        // One-cycle low glitch early in the HIGH phase of bit 0.
        press = '0;
        g = 0;
        while (!pad_latch && g < BOUND) begin step(); g++; end
        while (pad_latch && g < BOUND) begin step(); g++; end
        glitch = 1'b1;
        @(posedge clk);
        #1 glitch = 1'b0;
        while (!key.key_latch && g < BOUND) begin step(); g++; end
        check("glitch strobe seen", 32'(key.key_latch), 32'h1);
        check("glitch key_dec", 32'(key.key_dec), 32'h00);
        check("glitch buttons", 32'(key.buttons), 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
